// File: rtl/rambus_pkg.sv
// Shared types and default constants for the RamBus (APB-style) master.
package rambus_pkg;

    localparam int unsigned DEF_ADDR_W         = 14;
    localparam int unsigned DEF_DATA_W         = 32;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/rambus_master_if.sv
// Command/response handshake plus RamBus slave signals, bundled for the master.
interface rambus_master_if #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 32
) ();

    logic              CmdValid;
    logic              CmdReady;
    logic              CmdWrnRd;
    logic [ADDR_W-1:0] CmdAddress;
    logic [DATA_W-1:0] CmdData;
    logic              RspValid;
    logic [DATA_W-1:0] RspData;
    logic              RspErr;
    logic              RamBusnCs;
    logic              RamBusWrnRd;
    logic              RamBusLatch;
    logic [ADDR_W-1:0] RamBusAddress;
    logic [DATA_W-1:0] RamBusDataOut;
    logic [DATA_W-1:0] RamBusDataIn;
    logic              RamBusAck;

    // View of the master block itself.
    modport master (
        input  CmdValid, CmdWrnRd, CmdAddress, CmdData, RamBusDataIn, RamBusAck,
        output CmdReady, RspValid, RspData, RspErr,
               RamBusnCs, RamBusWrnRd, RamBusLatch, RamBusAddress, RamBusDataOut
    );

    // View of whatever drives commands and plays the slave.
    modport slave (
        output CmdValid, CmdWrnRd, CmdAddress, CmdData, RamBusDataIn, RamBusAck,
        input  CmdReady, RspValid, RspData, RspErr,
               RamBusnCs, RamBusWrnRd, RamBusLatch, RamBusAddress, RamBusDataOut
    );

endinterface

// File: rtl/rambus_timeout_counter.sv
// ACCESS-phase cycle counter; expire is high in the cycle that would make the
// count reach TIMEOUT_CYCLES, so the master leaves after TIMEOUT_CYCLES cycles.
module rambus_timeout_counter
    import rambus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear loads zero; otherwise count while enabled, saturating at expiry.
    always_comb begin
        expire = en && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        cnt_d  = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en && !expire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/rambus_master.sv
// RamBus master: one command at a time through IDLE -> SETUP -> ACCESS -> RESP.
// Optional ACCESS timeout is built when RAMBUS_MASTER_TIMEOUT_EN is defined.
module rambus_master
    import rambus_pkg::*;
#(
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    rambus_master_if.master bus
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("rambus_master: TIMEOUT_CYCLES must be at least 1");
    end

    state_e            state_q, state_d;
    logic              cs_q, cs_d;
    logic              latch_q, latch_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

`ifdef RAMBUS_MASTER_TIMEOUT_EN
    logic rsp_err_q, rsp_err_d;
    logic expire;

    rambus_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q != ST_ACCESS),
        .en     (state_q == ST_ACCESS),
        .expire (expire)
    );
`endif

    // Next state, registered command and response capture.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        rsp_data_d = rsp_data_q;
`ifdef RAMBUS_MASTER_TIMEOUT_EN
        rsp_err_d  = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.CmdValid) begin
                    state_d = ST_SETUP;
                    wr_d    = bus.CmdWrnRd;
                    addr_d  = bus.CmdAddress;
                    dout_d  = bus.CmdData;
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                // Ack has priority over a timeout landing in the same cycle.
                if (bus.RamBusAck) begin
                    state_d    = ST_RESP;
                    rsp_data_d = wr_q ? '0 : bus.RamBusDataIn;
`ifdef RAMBUS_MASTER_TIMEOUT_EN
                    rsp_err_d  = 1'b0;
                end else if (expire) begin
                    state_d    = ST_RESP;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
`endif
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Bus strobes are registered from the next state so they line up with it.
        cs_d        = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        latch_d     = (state_d == ST_ACCESS);
        rsp_valid_d = (state_d == ST_RESP);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cs_q        <= 1'b0;
            latch_q     <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            dout_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
`ifdef RAMBUS_MASTER_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cs_q        <= cs_d;
            latch_q     <= latch_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef RAMBUS_MASTER_TIMEOUT_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign bus.CmdReady      = (state_q == ST_IDLE);
    assign bus.RspValid      = rsp_valid_q;
    assign bus.RspData       = rsp_data_q;
    assign bus.RamBusnCs     = cs_q;
    assign bus.RamBusLatch   = latch_q;
    assign bus.RamBusWrnRd   = wr_q;
    assign bus.RamBusAddress = addr_q;
    assign bus.RamBusDataOut = dout_q;
`ifdef RAMBUS_MASTER_TIMEOUT_EN
    assign bus.RspErr        = rsp_err_q;
`else
    assign bus.RspErr        = 1'b0;
`endif

endmodule

// File: tb/tb_rambus_master.sv
// Self-checking bench for rambus_master: directed scenarios plus random
// transactions against a memory-backed slave model.
module tb_rambus_master;
    import rambus_pkg::*;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TMO    = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rambus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rambus_master #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;
    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction. The slave acks after 'waits' wait cycles; the
    // response cycle is expected (2 + waits) edges after the handshake edge,
    // i.e. the 4th cycle counting the handshake cycle when waits = 0.
    task automatic txn(input bit wr, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] data, input int waits,
                       input bit hold, output int hs_cyc);
        logic [DATA_W-1:0] exp_rsp;
        int n;
        bus.CmdValid   = 1'b1;
        bus.CmdWrnRd   = wr;
        bus.CmdAddress = addr;
        bus.CmdData    = data;
        n = 0;
        while (bus.CmdReady !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("cmd_ready_wait", bus.CmdReady, 1);
        step();
        hs_cyc = cyc;
        if (!hold) bus.CmdValid = 1'b0;
        if (wr) begin
            exp_rsp = '0;
        end else begin
            if (!mem.exists(addr)) mem[addr] = $urandom;
            exp_rsp = mem[addr];
        end
        check("setup_cs",    bus.RamBusnCs, 1);
        check("setup_latch", bus.RamBusLatch, 0);
        check("setup_addr",  bus.RamBusAddress, addr);
        check("setup_wr",    bus.RamBusWrnRd, wr);
        check("setup_dout",  bus.RamBusDataOut, data);
        check("setup_ready", bus.CmdReady, 0);
        check("setup_rspv",  bus.RspValid, 0);
        step();
        for (int k = 0; k <= waits; k++) begin
            check("access_cs",    bus.RamBusnCs, 1);
            check("access_latch", bus.RamBusLatch, 1);
            check("access_addr",  bus.RamBusAddress, addr);
            check("access_wr",    bus.RamBusWrnRd, wr);
            check("access_dout",  bus.RamBusDataOut, data);
            check("access_ready", bus.CmdReady, 0);
            check("access_rspv",  bus.RspValid, 0);
            bus.RamBusAck    = (k == waits);
            bus.RamBusDataIn = (k == waits && !wr) ? exp_rsp : DATA_W'($urandom);
            step();
        end
        bus.RamBusAck    = 1'b0;
        bus.RamBusDataIn = $urandom;
        if (wr) mem[addr] = data;
        check("rsp_valid",   bus.RspValid, 1);
        check("rsp_latency", 64'(cyc - hs_cyc), 64'(2 + waits));
        check("rsp_data",    bus.RspData, exp_rsp);
        check("rsp_err",     bus.RspErr, 0);
        check("rsp_cs",      bus.RamBusnCs, 0);
        check("rsp_latch",   bus.RamBusLatch, 0);
        check("rsp_ready",   bus.CmdReady, 0);
        step();
        check("idle_rspv",      bus.RspValid, 0);
        check("idle_ready",     bus.CmdReady, 1);
        check("idle_cs",        bus.RamBusnCs, 0);
        check("idle_rsp_hold",  bus.RspData, exp_rsp);
        check("idle_addr_hold", bus.RamBusAddress, addr);
        check("idle_dout_hold", bus.RamBusDataOut, data);
    endtask

`ifdef RAMBUS_MASTER_TIMEOUT_EN
    // Read that never gets acked, or gets acked exactly on the last allowed cycle.
    task automatic txn_timeout(input bit ack_last, input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] rd;
        rd = $urandom;
        bus.CmdValid   = 1'b1;
        bus.CmdWrnRd   = 1'b0;
        bus.CmdAddress = addr;
        bus.CmdData    = '0;
        step();
        bus.CmdValid = 1'b0;
        check("tmo_setup_cs", bus.RamBusnCs, 1);
        step();
        for (int k = 1; k <= int'(TMO); k++) begin
            check("tmo_access_cs",    bus.RamBusnCs, 1);
            check("tmo_access_latch", bus.RamBusLatch, 1);
            bus.RamBusAck    = ack_last && (k == int'(TMO));
            bus.RamBusDataIn = rd;
            step();
        end
        bus.RamBusAck = 1'b0;
        check("tmo_rsp_valid", bus.RspValid, 1);
        check("tmo_rsp_err",   bus.RspErr, !ack_last);
        check("tmo_rsp_data",  bus.RspData, ack_last ? rd : '0);
        step();
        check("tmo_idle_ready", bus.CmdReady, 1);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, h1, h2;
        bus.CmdValid     = 1'b0;
        bus.CmdWrnRd     = 1'b0;
        bus.CmdAddress   = '0;
        bus.CmdData      = '0;
        bus.RamBusDataIn = '0;
        bus.RamBusAck    = 1'b0;

        // Reset values.
        step();
        step();
        check("rst_cs",    bus.RamBusnCs, 0);
        check("rst_latch", bus.RamBusLatch, 0);
        check("rst_wr",    bus.RamBusWrnRd, 0);
        check("rst_rspv",  bus.RspValid, 0);
        check("rst_err",   bus.RspErr, 0);
        check("rst_addr",  bus.RamBusAddress, 0);
        check("rst_dout",  bus.RamBusDataOut, 0);
        check("rst_rdata", bus.RspData, 0);
        rst_n = 1'b1;
        step();
        check("post_rst_ready", bus.CmdReady, 1);

        // Write with immediate ack, then read with 5 wait states.
        txn(1'b1, 14'h0010, 32'hDEADBEEF, 0, 1'b0, h0);
        mem[14'h3FFF] = 32'h12345678;
        txn(1'b0, 14'h3FFF, 32'h0, 5, 1'b0, h0);

        // Stray ack while idle.
        bus.RamBusAck = 1'b1;
        step();
        bus.RamBusAck = 1'b0;
        check("stray_rspv",  bus.RspValid, 0);
        check("stray_ready", bus.CmdReady, 1);
        check("stray_cs",    bus.RamBusnCs, 0);
        step();
        check("stray_rspv2", bus.RspValid, 0);
        check("stray_hold",  bus.RspData, 32'h12345678);

        // Back-to-back with CmdValid held high: one accept every 4 cycles.
        txn(1'b1, 14'h0001, 32'hA5A5_0001, 0, 1'b1, h0);
        txn(1'b0, 14'h0001, 32'h0,         0, 1'b1, h1);
        txn(1'b1, 14'h0002, 32'hA5A5_0002, 0, 1'b0, h2);
        check("b2b_gap1", 64'(h1 - h0), 4);
        check("b2b_gap2", 64'(h2 - h1), 4);

        // Reset in the middle of ACCESS.
        bus.CmdValid   = 1'b1;
        bus.CmdWrnRd   = 1'b1;
        bus.CmdAddress = 14'h0123;
        bus.CmdData    = 32'hCAFE_F00D;
        step();
        bus.CmdValid = 1'b0;
        step();
        check("mid_in_access", bus.RamBusLatch, 1);
        rst_n = 1'b0;
        step();
        check("mid_rst_cs",    bus.RamBusnCs, 0);
        check("mid_rst_latch", bus.RamBusLatch, 0);
        check("mid_rst_rspv",  bus.RspValid, 0);
        check("mid_rst_addr",  bus.RamBusAddress, 0);
        rst_n = 1'b1;
        step();
        check("mid_rel_ready", bus.CmdReady, 1);
        check("mid_rel_rspv",  bus.RspValid, 0);
        txn(1'b0, 14'h0001, 32'h0, 2, 1'b0, h0);

`ifdef RAMBUS_MASTER_TIMEOUT_EN
        txn_timeout(1'b0, 14'h0444);
        txn_timeout(1'b1, 14'h0555);
`else
        // Without the timeout the master waits well past any fixed bound.
        txn(1'b0, 14'h0002, 32'h0, 20, 1'b0, h0);
`endif

        // Random traffic over a small address window so reads hit earlier writes.
        for (int i = 0; i < 16; i++) begin
            txn(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)),
                DATA_W'($urandom), int'($urandom_range(0, 4)), 1'b0, h0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
